// File: rtl/fraction_ascii_conv.sv
// Serial binary-fraction to ASCII decimal converter.
// Produces one decimal digit per clock by repeated multiply-by-ten of the
// residual. Digits are built in an internal shift register. The finished
// result is copied to o_ascii only when the conversion completes.
// Optional build macro: FRACTION_TRAIL_BLANK_EN replaces trailing zero
// digits with spaces. The first digit is never replaced.
module fraction_ascii_conv #(
    parameter int unsigned FRAC_W = 4,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [FRAC_W-1:0]     i_fraction,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [8*DIGITS-1:0]   o_ascii,
    input  logic                  i_ready
);

    localparam int unsigned PROD_W  = FRAC_W + 4;
    localparam int unsigned ASCII_W = 8 * DIGITS;
    localparam int unsigned CNT_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, next_state;

    logic [FRAC_W-1:0]    residual, residual_d;
    logic [CNT_W-1:0]     count, count_d;
    logic [ASCII_W-1:0]   shift, shift_d;
    logic [ASCII_W-1:0]   ascii_q, ascii_d;
    logic                 ready_q, ready_d;
    logic                 valid_q, valid_d;

    logic [PROD_W-1:0]    prod_c;
    logic [3:0]           digit_c;
    logic [ASCII_W-1:0]   shift_next_c;
    logic                 last_digit_c;

`ifdef FRACTION_TRAIL_BLANK_EN
    // Replace trailing '0' characters with spaces, keeping the leading digit.
    function automatic logic [ASCII_W-1:0] blank_trailing(input logic [ASCII_W-1:0] v);
        logic [ASCII_W-1:0] r;
        logic               seen_nonzero;
        r            = v;
        seen_nonzero = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (!seen_nonzero && (i != int'(DIGITS) - 1) && (v[8*i +: 8] == 8'h30)) begin
                r[8*i +: 8] = 8'h20;
            end else begin
                seen_nonzero = 1'b1;
            end
        end
        return r;
    endfunction
`endif

    // One digit step: multiply the residual by ten and split off the integer part.
    always_comb begin
        prod_c       = PROD_W'(residual) * PROD_W'(10);
        digit_c      = prod_c[PROD_W-1:FRAC_W];
        shift_next_c = (shift << 8) | ASCII_W'({4'h3, digit_c});
        last_digit_c = (count == CNT_W'(DIGITS - 1));
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (i_valid)      next_state = CONV;
            CONV: if (last_digit_c) next_state = DONE;
            DONE: if (i_ready)      next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        residual_d = residual;
        count_d    = count;
        shift_d    = shift;
        ascii_d    = ascii_q;
        ready_d    = (next_state == IDLE);
        valid_d    = (next_state == DONE);
        case (state)
            IDLE: begin
                if (i_valid) begin
                    residual_d = i_fraction;
                    count_d    = '0;
                    shift_d    = '0;
                end
            end
            CONV: begin
                residual_d = prod_c[FRAC_W-1:0];
                shift_d    = shift_next_c;
                count_d    = count + CNT_W'(1);
                if (last_digit_c) begin
`ifdef FRACTION_TRAIL_BLANK_EN
                    ascii_d = blank_trailing(shift_next_c);
`else
                    ascii_d = shift_next_c;
`endif
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            residual <= '0;
            count    <= '0;
            shift    <= '0;
            ascii_q  <= {DIGITS{8'h30}};
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            residual <= residual_d;
            count    <= count_d;
            shift    <= shift_d;
            ascii_q  <= ascii_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_ascii = ascii_q;

endmodule

// File: tb/tb_fraction_ascii_conv.sv
// Randomized self-checking bench for fraction_ascii_conv.
// Uses two instances: 4-bit/4-digit and 8-bit/8-digit.
module tb_fraction_ascii_conv;

    logic        clk;
    logic        rst;

    logic        v4, r4, rdy4, ov4;
    logic [3:0]  f4;
    logic [31:0] a4;

    logic        v8, r8, rdy8, ov8;
    logic [7:0]  f8;
    logic [63:0] a8;

    int          n_tests;
    int          n_fail;
    logic [63:0] prev4;
    logic [63:0] prev8;

    fraction_ascii_conv #(.FRAC_W(4), .DIGITS(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(v4), .i_fraction(f4),
        .o_ready(rdy4), .o_valid(ov4), .o_ascii(a4), .i_ready(r4)
    );

    fraction_ascii_conv #(.FRAC_W(8), .DIGITS(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .i_fraction(f8),
        .o_ready(rdy8), .o_valid(ov8), .o_ascii(a8), .i_ready(r8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: k-th decimal digit of f/2^w is floor(f*10^(k+1)/2^w) mod 10.
    function automatic logic [63:0] model(input int w, input int d, input longint f);
        int          dg[16];
        int          last;
        longint      pw;
        logic [63:0] r;
        logic [7:0]  ch;
        pw   = 1;
        last = 0;
        for (int k = 0; k < d; k++) begin
            pw    = pw * 10;
            dg[k] = int'(((f * pw) >> w) % 10);
            if (dg[k] != 0) last = k;
        end
        r = '0;
        for (int k = 0; k < d; k++) begin
            ch = 8'(8'h30 + dg[k]);
`ifdef FRACTION_TRAIL_BLANK_EN
            if (k > last) ch = 8'h20;
`endif
            r = (r << 8) | 64'(ch);
        end
        return r;
    endfunction

    task automatic conv4(input logic [3:0] f, input int hold);
        int          cyc;
        logic [63:0] exp;
        exp = model(4, 4, longint'(f));
        @(negedge clk);
        check("ready_idle4", 64'(rdy4), 64'd1);
        v4 = 1'b1;
        f4 = f;
        r4 = (hold == 0);
        @(negedge clk);
        v4 = 1'b0;
        f4 = 4'($urandom);
        check("ready_conv4", 64'(rdy4), 64'd0);
        check("hold_conv4", 64'(a4), prev4);
        cyc = 0;
        while (!ov4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency4", 64'(cyc), 64'd4);
        check("ascii4", 64'(a4), exp);
        for (int i = 0; i < hold; i++) begin
            v4 = 1'($urandom);
            f4 = 4'($urandom);
            @(negedge clk);
            check("hold_valid4", 64'(ov4), 64'd1);
            check("hold_ascii4", 64'(a4), exp);
            check("hold_ready4", 64'(rdy4), 64'd0);
        end
        v4 = 1'b0;
        r4 = 1'b1;
        @(negedge clk);
        check("release_valid4", 64'(ov4), 64'd0);
        check("release_ready4", 64'(rdy4), 64'd1);
        r4 = 1'b0;
        prev4 = exp;
    endtask

    task automatic conv8(input logic [7:0] f);
        int          cyc;
        logic [63:0] exp;
        exp = model(8, 8, longint'(f));
        @(negedge clk);
        v8 = 1'b1;
        f8 = f;
        r8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0;
        f8 = 8'($urandom);
        check("hold_conv8", a8, prev8);
        cyc = 0;
        while (!ov8 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("latency8", 64'(cyc), 64'd8);
        check("ascii8", a8, exp);
        @(negedge clk);
        check("release_valid8", 64'(ov8), 64'd0);
        r8 = 1'b0;
        prev8 = exp;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        v4 = 1'b0; r4 = 1'b0; f4 = '0;
        v8 = 1'b0; r8 = 1'b0; f8 = '0;
        rst = 1'b1;
        prev4 = 64'h30303030;
        prev8 = 64'h3030303030303030;
        #12;
        check("rst_valid", 64'(ov4), 64'd0);
        check("rst_ascii", 64'(a4), 64'h30303030);
        check("rst_ascii8", a8, 64'h3030303030303030);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 64'(rdy4), 64'd1);

        // Directed values, then a long hold in DONE.
        conv4(4'b1000, 0);
        conv4(4'b0001, 0);
        conv4(4'b1111, 0);
        conv4(4'b0000, 0);
        conv4(4'b0110, 10);

        // Reset in the middle of a conversion.
        @(negedge clk);
        v4 = 1'b1;
        f4 = 4'b1111;
        @(negedge clk);
        v4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(ov4), 64'd0);
        check("midrst_ascii", 64'(a4), 64'h30303030);
        @(negedge clk);
        rst = 1'b0;
        prev4 = 64'h30303030;
        prev8 = 64'h3030303030303030;
        conv4(4'b0100, 0);

        // Randomized conversions with random DONE hold times.
        for (int i = 0; i < 24; i++) begin
            conv4(4'($urandom), int'($urandom_range(0, 3)));
        end

        conv8(8'h01);
        conv8(8'hFF);
        for (int i = 0; i < 8; i++) begin
            conv8(8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
